svm_sample_feeder: RTL and testbench

//  Initiator side of the hw_svm classification stream.
//  - Reads N_SAMPLES x N_FEAT signed feature words from a 1-cycle-latency read port.
//  - Presents them to hw_svm on test/test_valid/test_ready.
//  - Consumes one label per sample on label/label_valid/label_ready.
//  - Reports every label, plus a running positive count, to the host/control logic.

---
 rtl/svm_pkg.sv | 15 +
 rtl/svm_feed_buf.sv | 55 +++++
 rtl/svm_sample_feeder.sv | 141 ++++++++++++++
 tb/tb_svm_sample_feeder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared types for the hw_svm sample feeder: feature word type and feeder FSM states.
package svm_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  typedef logic signed [DEF_DATA_W-1:0] feat_t;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    WAIT_LABEL,
    DONE
  } feeder_state_e;

endpackage

// File: rtl/svm_feed_buf.sv
// Two-entry feature FIFO between the read port and the test stream.
// Entry 0 is always the head, so the head output needs no read mux.
module svm_feed_buf
  import svm_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] head_o,
  output logic [1:0]               count_o
);

  logic signed [DATA_W-1:0] e0_q, e1_q;
  logic [1:0]               cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= din_i;
          end else begin
            e0_q <= din_i;
          end
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= din_i;
          else               e1_q <= din_i;
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/svm_sample_feeder.sv
// Initiator side of the hw_svm stream: fetches feature words, streams them out,
// collects one label per sample and keeps a running positive count.
module svm_sample_feeder
  import svm_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned N_FEAT    = 16,
  parameter int unsigned N_SAMPLES = 64,
  parameter int unsigned ADDR_W    = $clog2(N_FEAT*N_SAMPLES),
  parameter int unsigned CNT_W     = $clog2(N_SAMPLES+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic signed [DATA_W-1:0]       mem_rdata,
  output logic signed [DATA_W-1:0]       test,
  output logic                           test_valid,
  input  logic                           test_ready,
  input  logic                           label,
  input  logic                           label_valid,
  output logic                           label_ready,
  output logic                           res_valid,
  output logic [$clog2(N_SAMPLES)-1:0]   res_idx,
  output logic                           res_label,
  output logic [CNT_W-1:0]               pos_count
);

  localparam int unsigned IDX_W = $clog2(N_SAMPLES);
  localparam int unsigned FC_W  = $clog2(N_FEAT+1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SAMPLES-1);
  localparam logic [FC_W-1:0]  FEAT_N    = FC_W'(N_FEAT);
  localparam logic [FC_W-1:0]  LAST_FEAT = FC_W'(N_FEAT-1);

  feeder_state_e     state_q;
  logic [IDX_W-1:0]  sample_q;
  logic [FC_W-1:0]   issued_q, sent_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  pos_q;
  logic              res_valid_q, res_label_q;
  logic [IDX_W-1:0]  res_idx_q;

  logic              in_feed, pop, push, flush;
  logic [1:0]        buf_cnt, credit;
  logic signed [DATA_W-1:0] buf_head;

  assign in_feed = (state_q == FEED);
  assign test_valid = in_feed && (buf_cnt != 2'd0);
  assign pop   = test_valid && test_ready;
  assign push  = inflight_q && in_feed && !abort;
  assign flush = abort && (state_q != IDLE);

  // A slot freed by this cycle's pop counts as credit, otherwise the
  // 1-cycle read latency would leave a bubble every third word.
  assign credit = buf_cnt + {1'b0, inflight_q};
  assign mem_rd = in_feed && (issued_q < FEAT_N) &&
                  ((credit < 2'd2) || ((credit == 2'd2) && pop));
  assign mem_addr = ADDR_W'(sample_q) * ADDR_W'(N_FEAT) + ADDR_W'(issued_q);

  svm_feed_buf #(.DATA_W(DATA_W)) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (mem_rdata),
    .head_o  (buf_head),
    .count_o (buf_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      inflight_q  <= 1'b0;
      pos_q       <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_label_q <= 1'b0;
    end else begin
      inflight_q  <= mem_rd && !abort;
      res_valid_q <= 1'b0;
      if (mem_rd) issued_q <= issued_q + FC_W'(1);
      if (pop)    sent_q   <= sent_q + FC_W'(1);
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= FEED;
            sample_q <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            pos_q    <= '0;
          end
        end
        FEED: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (pop && (sent_q == LAST_FEAT)) begin
            state_q  <= WAIT_LABEL;
            issued_q <= '0;
            sent_q   <= '0;
          end
        end
        WAIT_LABEL: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (label_valid) begin
            res_valid_q <= 1'b1;
            res_idx_q   <= sample_q;
            res_label_q <= label;
            pos_q       <= pos_q + CNT_W'(label);
            if (sample_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              state_q  <= FEED;
              sample_q <= sample_q + IDX_W'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign test        = buf_head;
  assign busy        = in_feed || (state_q == WAIT_LABEL);
  assign done        = (state_q == DONE);
  assign label_ready = (state_q == WAIT_LABEL);
  assign res_valid   = res_valid_q;
  assign res_idx     = res_idx_q;
  assign res_label   = res_label_q;
  assign pos_count   = pos_q;

endmodule

// File: tb/tb_svm_sample_feeder.sv
// Directed bench for svm_sample_feeder with N_FEAT=4, N_SAMPLES=2 and mem[i]=0xa24e+i.
module tb_svm_sample_feeder;
  import svm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        busy, done, mem_rd;
  logic [2:0]  mem_addr;
  feat_t       mem_rdata, test;
  logic        test_valid, test_ready;
  logic        label, label_valid, label_ready;
  logic        res_valid, res_label;
  logic [0:0]  res_idx;
  logic [1:0]  pos_count;

  int nchk = 0;
  int nerr = 0;

  feat_t mem [8];
  logic  pat [6];

  svm_sample_feeder #(.N_FEAT(4), .N_SAMPLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .test(test), .test_valid(test_valid), .test_ready(test_ready),
    .label(label), .label_valid(label_valid), .label_ready(label_ready),
    .res_valid(res_valid), .res_idx(res_idx), .res_label(res_label),
    .pos_count(pos_count)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // stim = {start, label_valid, label}; flags = {tv, rd, lrdy, rv, rlbl, busy, done}
  typedef struct {
    logic [2:0]  stim;
    logic [6:0]  flags;
    logic [31:0] tdata;
    logic [2:0]  addr;
    logic        ridx;
    logic [1:0]  pos;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams one sample, checking word order and hold-while-stalled, until WAIT_LABEL.
  task automatic run_feed(input int base, input bit stall);
    int got = 0;
    int cyc = 0;
    bit held = 1'b0;
    feat_t hold = '0;
    while (got < 4 && cyc < 60) begin
      test_ready = stall ? pat[cyc % 6] : 1'b1;
      #1;
      if (held) chk($sformatf("hold s%0d w%0d", base, got), {test_valid, test}, {1'b1, hold});
      held = 1'b0;
      if (test_valid) begin
        if (test_ready) begin
          chk($sformatf("word s%0d w%0d", base, got), test, 32'ha24e + base + got);
          got++;
        end else begin
          hold = test;
          held = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    test_ready = 1'b1;
    chk($sformatf("word count s%0d", base), got, 4);
    chk($sformatf("enter wait s%0d", base), {label_ready, test_valid}, 2'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'ha24e + i;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    tbl[0]  = '{3'b100, 7'b0100010, 32'h0,    3'd0, 1'b0, 2'd0};
    tbl[1]  = '{3'b000, 7'b0100010, 32'h0,    3'd1, 1'b0, 2'd0};
    tbl[2]  = '{3'b000, 7'b1100010, 32'ha24e, 3'd2, 1'b0, 2'd0};
    tbl[3]  = '{3'b011, 7'b1100010, 32'ha24f, 3'd3, 1'b0, 2'd0};
    tbl[4]  = '{3'b011, 7'b1000010, 32'ha250, 3'd0, 1'b0, 2'd0};
    tbl[5]  = '{3'b011, 7'b1000010, 32'ha251, 3'd0, 1'b0, 2'd0};
    tbl[6]  = '{3'b011, 7'b0010010, 32'h0,    3'd0, 1'b0, 2'd0};
    tbl[7]  = '{3'b011, 7'b0101110, 32'h0,    3'd4, 1'b0, 2'd1};
    tbl[8]  = '{3'b000, 7'b0100010, 32'h0,    3'd5, 1'b0, 2'd1};
    tbl[9]  = '{3'b000, 7'b1100010, 32'ha252, 3'd6, 1'b0, 2'd1};
    tbl[10] = '{3'b000, 7'b1100010, 32'ha253, 3'd7, 1'b0, 2'd1};
    tbl[11] = '{3'b000, 7'b1000010, 32'ha254, 3'd0, 1'b0, 2'd1};
    tbl[12] = '{3'b000, 7'b1000010, 32'ha255, 3'd0, 1'b0, 2'd1};
    tbl[13] = '{3'b000, 7'b0010010, 32'h0,    3'd0, 1'b0, 2'd1};
    tbl[14] = '{3'b010, 7'b0001001, 32'h0,    3'd0, 1'b1, 2'd1};
    tbl[15] = '{3'b000, 7'b0000000, 32'h0,    3'd0, 1'b0, 2'd1};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    test_ready = 1'b1; label_valid = 1'b0; label = 1'b0;
    #2;
    chk("reset outputs",
        {busy, done, mem_rd, test_valid, label_ready, res_valid, res_label, pos_count, test},
        '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Full run, test_ready high, early label_valid during FEED, labels 1 then 0
    for (int r = 0; r < 16; r++) begin
      {start, label_valid, label} = tbl[r].stim;
      @(posedge clk); #1;
      chk($sformatf("row%0d test_valid", r),  test_valid,  tbl[r].flags[6]);
      chk($sformatf("row%0d mem_rd", r),      mem_rd,      tbl[r].flags[5]);
      chk($sformatf("row%0d label_ready", r), label_ready, tbl[r].flags[4]);
      chk($sformatf("row%0d res_valid", r),   res_valid,   tbl[r].flags[3]);
      chk($sformatf("row%0d busy", r),        busy,        tbl[r].flags[1]);
      chk($sformatf("row%0d done", r),        done,        tbl[r].flags[0]);
      chk($sformatf("row%0d pos_count", r),   pos_count,   tbl[r].pos);
      if (tbl[r].flags[6]) chk($sformatf("row%0d test", r), test, tbl[r].tdata);
      if (tbl[r].flags[5]) chk($sformatf("row%0d mem_addr", r), mem_addr, tbl[r].addr);
      if (tbl[r].flags[3]) begin
        chk($sformatf("row%0d res_idx", r),   res_idx,   tbl[r].ridx);
        chk($sformatf("row%0d res_label", r), res_label, tbl[r].flags[2]);
      end
    end
    {start, label_valid, label} = 3'b000;

    // Stalled stream, then async reset while waiting for the second label
    do_start();
    run_feed(0, 1'b1);
    label_valid = 1'b1; label = 1'b1;
    @(posedge clk); #1;
    label_valid = 1'b0;
    chk("stall capture", {res_valid, res_idx, res_label, pos_count}, {1'b1, 1'b0, 1'b1, 2'd1});
    run_feed(4, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async reset mid-wait",
        {busy, done, mem_rd, test_valid, label_ready, res_valid, res_label, pos_count, test},
        '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Abort while the first read's data is returning
    do_start();
    chk("abort pre rd", {mem_rd, mem_addr}, {1'b1, 3'd0});
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort idle", {busy, done, test_valid, label_ready}, 4'b0000);
    @(posedge clk); #1;
    chk("abort data dropped", {test_valid, busy}, 2'b00);

    // Restart from address 0, then abort in WAIT_LABEL with a label pending
    do_start();
    run_feed(0, 1'b0);
    label_valid = 1'b1; label = 1'b1;
    @(posedge clk); #1;
    label_valid = 1'b0;
    chk("restart capture", {res_valid, res_idx, pos_count}, {1'b1, 1'b0, 2'd1});
    run_feed(4, 1'b0);
    abort = 1'b1; label_valid = 1'b1; label = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; label_valid = 1'b0;
    chk("abort beats label", {res_valid, pos_count, busy, done, label_ready}, {1'b0, 2'd1, 3'b000});
    @(posedge clk); #1;
    chk("abort no done", {done, busy, pos_count}, {2'b00, 2'd1});

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
